alu_share_arbiter: RTL and testbench

Two-port arbiter that time-shares the single combinational ALU between two requesters, for example the main pipeline execute stage and a multi-cycle helper such as an address or branch unit. It accepts one operation at a time through a valid/ready handshake and drives the ALU from registered operands. It captures the ALU result and returns it to the owning requester through a per-port response handshake. Arbitration is round-robin by default, with an optional fixed-priority mode.

---
 rtl/alu_share_arbiter.sv | 129 ++++++++++++
 tb/tb_alu_share_arbiter.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arbiter.sv
// Time-shares one combinational ALU between two requesters.
// Each operation is accepted, run for one cycle from registered operands, and its result is held until the owner takes it.
module alu_share_arbiter #(
  parameter bit PRIO_FIXED = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic [31:0] req0_a,
  input  logic [31:0] req0_b,
  input  logic [5:0]  req0_fun,
  input  logic        req0_sign,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic [31:0] req1_a,
  input  logic [31:0] req1_b,
  input  logic [5:0]  req1_fun,
  input  logic        req1_sign,
  output logic        rsp0_valid,
  input  logic        rsp0_ready,
  output logic        rsp1_valid,
  input  logic        rsp1_ready,
  output logic [31:0] rsp_data,
  output logic [31:0] alu_a,
  output logic [31:0] alu_b,
  output logic [5:0]  alu_fun,
  output logic        alu_sign,
  input  logic [31:0] alu_res,
  output logic        busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        last_grant_q;
  logic        owner_q;
  logic [31:0] op_a_q, op_b_q;
  logic [5:0]  op_fun_q;
  logic        op_sign_q;
  logic [31:0] rsp_data_q;

  logic        grant;
  logic        accept;
  logic        owner_ready;

  // Port 0 wins a tie in fixed mode; otherwise the port that did not win last time.
  always_comb begin
    grant = 1'b0;
    if (req0_valid && req1_valid) begin
      grant = PRIO_FIXED ? 1'b0 : ~last_grant_q;
    end else if (req1_valid) begin
      grant = 1'b1;
    end
  end

  assign accept      = (req0_valid && req0_ready) || (req1_valid && req1_ready);
  assign owner_ready = owner_q ? rsp1_ready : rsp0_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = EXEC;
      EXEC:    state_d = RESP;
      RESP:    if (owner_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Ready is gated by rst_n so nothing can appear accepted while reset is held.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    busy       = (state_q != IDLE);
    if (state_q == IDLE && rst_n) begin
      req0_ready = req0_valid && !grant;
      req1_ready = req1_valid && grant;
    end
    if (state_q == RESP) begin
      rsp0_valid = !owner_q;
      rsp1_valid = owner_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant_q <= 1'b1;
      owner_q      <= 1'b0;
      op_a_q       <= '0;
      op_b_q       <= '0;
      op_fun_q     <= '0;
      op_sign_q    <= 1'b0;
      rsp_data_q   <= '0;
    end else begin
      if (state_q == IDLE && accept) begin
        owner_q      <= grant;
        last_grant_q <= grant;
        op_a_q       <= grant ? req1_a    : req0_a;
        op_b_q       <= grant ? req1_b    : req0_b;
        op_fun_q     <= grant ? req1_fun  : req0_fun;
        op_sign_q    <= grant ? req1_sign : req0_sign;
      end
      if (state_q == EXEC) begin
        rsp_data_q <= alu_res;
      end
    end
  end

  assign alu_a    = op_a_q;
  assign alu_b    = op_b_q;
  assign alu_fun  = op_fun_q;
  assign alu_sign = op_sign_q;
  assign rsp_data = rsp_data_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Two arbiters (index 0 round-robin, index 1 fixed priority), each feeding a bench ALU,
// checked every cycle against a transaction-level model plus directed literal checks.
module tb_alu_share_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  req_v [2];
  logic [31:0] req_a [2][2];
  logic [31:0] req_b [2][2];
  logic [5:0]  req_fun [2][2];
  logic        req_sign [2][2];
  logic [1:0]  rsp_r [2];
  logic        req0_rdy [2], req1_rdy [2];
  logic        rsp0_v [2], rsp1_v [2];
  logic [31:0] rsp_data [2], alu_a [2], alu_b [2], alu_res [2];
  logic [5:0]  alu_fun [2];
  logic        alu_sign [2];
  logic        busy [2];

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                        input logic [5:0] f, input logic s);
    logic [31:0] r;
    r = '0;
    case (f[5:4])
      2'b00: r = f[0] ? a - b : a + b;
      2'b01: case (f[1:0])
               2'd0: r = a & b;
               2'd1: r = a | b;
               2'd2: r = a ^ b;
               default: r = ~(a | b);
             endcase
      2'b10: case (f[1:0])
               2'd0: r = a << b[4:0];
               2'd1: r = a >> b[4:0];
               default: r = s ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
             endcase
      default: r = {31'd0, s ? ($signed(a) < $signed(b)) : (a < b)};
    endcase
    return r;
  endfunction

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    alu_share_arbiter #(.PRIO_FIXED(gi == 1)) u_dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req0_valid (req_v[gi][0]),
      .req0_ready (req0_rdy[gi]),
      .req0_a     (req_a[gi][0]),
      .req0_b     (req_b[gi][0]),
      .req0_fun   (req_fun[gi][0]),
      .req0_sign  (req_sign[gi][0]),
      .req1_valid (req_v[gi][1]),
      .req1_ready (req1_rdy[gi]),
      .req1_a     (req_a[gi][1]),
      .req1_b     (req_b[gi][1]),
      .req1_fun   (req_fun[gi][1]),
      .req1_sign  (req_sign[gi][1]),
      .rsp0_valid (rsp0_v[gi]),
      .rsp0_ready (rsp_r[gi][0]),
      .rsp1_valid (rsp1_v[gi]),
      .rsp1_ready (rsp_r[gi][1]),
      .rsp_data   (rsp_data[gi]),
      .alu_a      (alu_a[gi]),
      .alu_b      (alu_b[gi]),
      .alu_fun    (alu_fun[gi]),
      .alu_sign   (alu_sign[gi]),
      .alu_res    (alu_res[gi]),
      .busy       (busy[gi])
    );
    assign alu_res[gi] = alu_f(alu_a[gi], alu_b[gi], alu_fun[gi], alu_sign[gi]);
  end

  task automatic chk(input int inst, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL inst=%0d %s got=%h exp=%h t=%0t", inst, nm, act, exp, $time);
    end
  endtask

  // Transaction model: an op in flight is EXEC on its first cycle and RESP after that.
  logic        m_busy [2], m_owner [2], m_lg [2], m_sign [2];
  int          m_age [2];
  logic [31:0] m_a [2], m_b [2], m_res [2], m_rdata [2];
  logic [5:0]  m_fun [2];

  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      logic [1:0] v, e_rdy, e_rv;
      logic g;
      if (!rst_n) begin
        m_busy[i] = 1'b0; m_age[i] = 0; m_owner[i] = 1'b0; m_lg[i] = 1'b1;
        m_a[i] = '0; m_b[i] = '0; m_fun[i] = '0; m_sign[i] = 1'b0; m_rdata[i] = '0;
      end
      v = req_v[i];
      e_rdy = 2'b00;
      e_rv = 2'b00;
      if (v == 2'b11) g = (i == 1) ? 1'b0 : ~m_lg[i];
      else g = v[1];
      if (rst_n && !m_busy[i] && v != 2'b00) e_rdy[g] = 1'b1;
      if (m_busy[i] && m_age[i] >= 1) e_rv[m_owner[i]] = 1'b1;
      chk(i, "req0_ready", req0_rdy[i], e_rdy[0]);
      chk(i, "req1_ready", req1_rdy[i], e_rdy[1]);
      chk(i, "rsp0_valid", rsp0_v[i], e_rv[0]);
      chk(i, "rsp1_valid", rsp1_v[i], e_rv[1]);
      chk(i, "busy", busy[i], m_busy[i]);
      chk(i, "rsp_data", rsp_data[i], m_rdata[i]);
      chk(i, "alu_a", alu_a[i], m_a[i]);
      chk(i, "alu_b", alu_b[i], m_b[i]);
      chk(i, "alu_fun", alu_fun[i], m_fun[i]);
      chk(i, "alu_sign", alu_sign[i], m_sign[i]);
      if (rst_n) begin
        if (!m_busy[i]) begin
          if (v != 2'b00) begin
            m_busy[i] = 1'b1; m_age[i] = 0; m_owner[i] = g; m_lg[i] = g;
            m_a[i] = req_a[i][g]; m_b[i] = req_b[i][g];
            m_fun[i] = req_fun[i][g]; m_sign[i] = req_sign[i][g];
            m_res[i] = alu_f(m_a[i], m_b[i], m_fun[i], m_sign[i]);
          end
        end else if (m_age[i] == 0) begin
          m_age[i] = 1;
          m_rdata[i] = m_res[i];
        end else if (rsp_r[i][m_owner[i]]) begin
          m_busy[i] = 1'b0;
          $display("txn inst=%0d port=%0d a=%h b=%h fun=%b sign=%0d res=%h",
                   i, m_owner[i], m_a[i], m_b[i], m_fun[i], m_sign[i], m_rdata[i]);
        end
      end
    end
  end

  task automatic set_req(input int i, input int p, input logic [31:0] a, input logic [31:0] b,
                         input logic [5:0] f, input logic s);
    req_a[i][p] = a; req_b[i][p] = b; req_fun[i][p] = f; req_sign[i][p] = s;
    req_v[i][p] = 1'b1;
  endtask

  task automatic wait_grant(input int i, input int p);
    logic ok;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge clk);
      ok = (p == 0) ? req0_rdy[i] : req1_rdy[i];
    end
    chk(i, "grant_wait", ok, 1);
  endtask

  task automatic issue(input int i, input int p, input logic [31:0] a, input logic [31:0] b,
                       input logic [5:0] f, input logic s);
    set_req(i, p, a, b, f, s);
    wait_grant(i, p);
    @(posedge clk); #1;
    req_v[i][p] = 1'b0;
  endtask

  // Both ports held valid: port 0 computes 10+1, port 1 computes 100-1.
  task automatic tie_loop(input int i, input int n, input logic alt);
    logic ok, g;
    for (int k = 0; k < n; k++) begin
      ok = 1'b0;
      g = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
        @(negedge clk);
        ok = req0_rdy[i] | req1_rdy[i];
        g = req1_rdy[i];
      end
      chk(i, "tie_wait", ok, 1);
      chk(i, "tie_grant", g, alt ? k % 2 : 0);
      @(negedge clk);
      @(negedge clk);
      chk(i, "tie_rspv", g ? rsp1_v[i] : rsp0_v[i], 1);
      chk(i, "tie_data", rsp_data[i], g ? 32'd99 : 32'd11);
    end
    @(posedge clk); #1;
  endtask

  task automatic rand_drive(input int i, input int cycles);
    logic [1:0] hs;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      hs = req_v[i] & {req1_rdy[i], req0_rdy[i]};
      @(posedge clk); #1;
      for (int p = 0; p < 2; p++) begin
        if (hs[p] || !req_v[i][p]) begin
          if ($urandom_range(0, 2) != 0) set_req(i, p, $urandom, $urandom, 6'($urandom), 1'($urandom));
          else req_v[i][p] = 1'b0;
        end else if ($urandom_range(0, 15) == 0) begin
          req_v[i][p] = 1'b0;
        end
      end
      rsp_r[i] = 2'($urandom);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_v[i] = 2'b00;
      rsp_r[i] = 2'b00;
      for (int p = 0; p < 2; p++) begin
        req_a[i][p] = '0; req_b[i][p] = '0; req_fun[i][p] = '0; req_sign[i][p] = 1'b0;
      end
    end
    req_v[0] = 2'b01;
    repeat (2) @(negedge clk);
    chk(0, "rst_req0_ready", req0_rdy[0], 0);
    chk(0, "rst_busy", busy[0], 0);
    @(posedge clk); #1;
    req_v[0] = 2'b00;
    rst_n = 1'b1;
    rsp_r[0] = 2'b11;
    rsp_r[1] = 2'b11;

    // Single add on port 0
    issue(0, 0, 32'd5, 32'd7, 6'b000000, 1'b0);
    @(negedge clk);
    chk(0, "t1_exec_rsp0v", rsp0_v[0], 0);
    chk(0, "t1_exec_busy", busy[0], 1);
    @(negedge clk);
    chk(0, "t1_rsp0v", rsp0_v[0], 1);
    chk(0, "t1_data", rsp_data[0], 32'h0000000C);
    chk(0, "t1_rsp1v", rsp1_v[0], 0);
    @(posedge clk); #1;

    // Signed subtract on port 1
    issue(0, 1, 32'd3, 32'd5, 6'b000001, 1'b1);
    @(negedge clk);
    chk(0, "t2_exec_fun", alu_fun[0], 32'h1);
    chk(0, "t2_exec_a", alu_a[0], 32'd3);
    @(negedge clk);
    chk(0, "t2_rsp1v", rsp1_v[0], 1);
    chk(0, "t2_data", rsp_data[0], 32'hFFFFFFFE);
    chk(0, "t2_rsp0v", rsp0_v[0], 0);
    @(posedge clk); #1;

    // Round-robin tie, last grant was port 1 so port 0 starts
    set_req(0, 0, 32'd10, 32'd1, 6'b000000, 1'b0);
    set_req(0, 1, 32'd100, 32'd1, 6'b000001, 1'b0);
    tie_loop(0, 4, 1'b1);
    req_v[0] = 2'b00;

    // Fixed priority: port 0 every time, port 1 only once port 0 drops
    set_req(1, 0, 32'd10, 32'd1, 6'b000000, 1'b0);
    set_req(1, 1, 32'd100, 32'd1, 6'b000001, 1'b0);
    tie_loop(1, 3, 1'b0);
    req_v[1][0] = 1'b0;
    wait_grant(1, 1);
    @(posedge clk); #1;
    req_v[1][1] = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk(1, "fp_rsp1v", rsp1_v[1], 1);
    chk(1, "fp_data", rsp_data[1], 32'd99);
    @(posedge clk); #1;

    // Response backpressure with port 1 waiting
    rsp_r[0] = 2'b00;
    issue(0, 0, 32'h1234, 32'h1, 6'b000000, 1'b0);
    set_req(0, 1, 32'd40, 32'd2, 6'b000000, 1'b0);
    @(negedge clk);
    repeat (5) begin
      @(negedge clk);
      chk(0, "bp_rsp0v", rsp0_v[0], 1);
      chk(0, "bp_data", rsp_data[0], 32'h1235);
      chk(0, "bp_busy", busy[0], 1);
      chk(0, "bp_req1_ready", req1_rdy[0], 0);
    end
    @(posedge clk); #1;
    rsp_r[0] = 2'b01;
    @(negedge clk);
    @(negedge clk);
    chk(0, "bp_next_req1_ready", req1_rdy[0], 1);
    @(posedge clk); #1;
    req_v[0][1] = 1'b0;
    rsp_r[0] = 2'b10;
    @(negedge clk);
    @(negedge clk);
    chk(0, "bp_rsp1v", rsp1_v[0], 1);
    chk(0, "bp_data1", rsp_data[0], 32'd42);
    @(posedge clk); #1;
    rsp_r[0] = 2'b11;

    // Reset during EXEC discards the op
    issue(0, 0, 32'd9, 32'd9, 6'b000000, 1'b0);
    rst_n = 1'b0;
    #1;
    chk(0, "rx_busy", busy[0], 0);
    chk(0, "rx_rsp0v", rsp0_v[0], 0);
    chk(0, "rx_alu_a", alu_a[0], 0);
    chk(0, "rx_rsp_data", rsp_data[0], 0);
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk(0, "rx_no_rsp", rsp0_v[0], 0);
      chk(0, "rx_idle", busy[0], 0);
    end
    @(posedge clk); #1;
    issue(0, 0, 32'd20, 32'd22, 6'b000000, 1'b0);
    @(negedge clk);
    @(negedge clk);
    chk(0, "rx_after_rsp0v", rsp0_v[0], 1);
    chk(0, "rx_after_data", rsp_data[0], 32'd42);
    @(posedge clk); #1;

    // Randomized traffic on both arbiters
    fork
      rand_drive(0, 400);
      rand_drive(1, 400);
    join
    req_v[0] = 2'b00;
    req_v[1] = 2'b00;
    rsp_r[0] = 2'b11;
    rsp_r[1] = 2'b11;
    repeat (6) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
